// File: rtl/blob_source_pkg.sv
`default_nettype none
// ============================================================================
// Module : blob_source_pkg
// Brief  : Shared state encoding and map-size helpers for the blob source.
// Rev    : 1.0
// ============================================================================
package blob_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  function automatic int unsigned blob_words(input int unsigned w,
                                             input int unsigned h,
                                             input int unsigned c);
    return w * h * c;
  endfunction

  // One extra bit so a full 2**ADDR_WIDTH map never aliases to zero.
  function automatic int unsigned blob_cnt_width(input int unsigned aw);
    return aw + 1;
  endfunction

  localparam int unsigned c_default_n     = blob_words(32, 32, 3);
  localparam int unsigned c_default_cnt_w = blob_cnt_width(12);

endpackage
`default_nettype wire

// File: rtl/blob_source_ram.sv
`default_nettype none
// ============================================================================
// Module : blob_source_ram
// Brief  : Simple dual-port RAM, write on port A, registered read on port B.
// Rev    : 1.0
// ============================================================================
module blob_source_ram
  import blob_source_pkg::*;
#(
  parameter int DIN_W      = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clka,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DIN_W-1:0]      dina,
  input  logic                  clkb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DIN_W-1:0]      doutb
);

  localparam int unsigned c_depth = 1 << ADDR_WIDTH;

  logic [DIN_W-1:0] mem_q [c_depth];

  always_ff @(posedge clka) begin
    if (wea) begin
      mem_q[addra] <= dina;
    end
  end

  always_ff @(posedge clkb) begin
    doutb <= mem_q[addrb];
  end

endmodule
`default_nettype wire

// File: rtl/blob_source.sv
`default_nettype none
// ============================================================================
// Module : blob_source
// Brief  : Buffers one feature map and streams it onto the blob handshake.
// Rev    : 1.0
// ============================================================================
module blob_source
  import blob_source_pkg::*;
#(
  parameter int DB_W       = 32,
  parameter int DB_H       = 32,
  parameter int DB_C       = 3,
  parameter int DIN_W      = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_wr_en,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [DIN_W-1:0]      host_wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  blob_dout_rdy,
  output logic                  blob_dout_en,
  output logic                  blob_dout_eop,
  output logic [DIN_W-1:0]      blob_dout
);

  localparam int unsigned         c_n     = blob_words(DB_W, DB_H, DB_C);
  localparam int unsigned         c_cnt_w = blob_cnt_width(ADDR_WIDTH);
  localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(c_n - 1);

  generate
    if (64'(c_n) > (64'd1 << ADDR_WIDTH)) begin : g_size_check
      $error("blob_source: DB_W*DB_H*DB_C exceeds 2**ADDR_WIDTH");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               v1_q, v1_d;
  logic               eop1_q, eop1_d;
  logic               en_q, en_d;
  logic               eop_q, eop_d;
  logic [DIN_W-1:0]   dout_q, dout_d;

  logic               ram_we;
  logic [DIN_W-1:0]   ram_dout;

  assign ram_we = host_wr_en && (state_q == ST_IDLE);

  blob_source_ram #(
    .DIN_W      (DIN_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clka  (clk),
    .wea   (ram_we),
    .addra (host_wr_addr),
    .dina  (host_wr_data),
    .clkb  (clk),
    .addrb (cnt_q[ADDR_WIDTH-1:0]),
    .doutb (ram_dout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    v1_d    = 1'b0;
    eop1_d  = 1'b0;
    // Second pipeline stage lines up with the RAM read latency.
    en_d    = v1_q;
    eop_d   = eop1_q;
    dout_d  = v1_q ? ram_dout : dout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_STREAM: begin
        if (blob_dout_rdy) begin
          v1_d   = 1'b1;
          eop1_d = (cnt_q == c_last);
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == c_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (eop_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      eop1_q  <= 1'b0;
      en_q    <= 1'b0;
      eop_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      v1_q    <= v1_d;
      eop1_q  <= eop1_d;
      en_q    <= en_d;
      eop_q   <= eop_d;
      dout_q  <= dout_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign blob_dout_en  = en_q;
  assign blob_dout_eop = eop_q;
  assign blob_dout     = dout_q;

endmodule
`default_nettype wire

// File: doc/blob_source.md
# blob_source

Streaming transmitter that drives the blob handshake from the producer side: it holds one input feature map in a local buffer and streams it word by word into the first layer's `blob_din*` port. A host fills the buffer through a simple write port. A `start` pulse releases the whole map, and the last word is marked with `eop`. It sits in front of the layer chain (and in layer-level benches) as the counterpart of a layer's blob input.

## Interface
Parameters:
- `DB_W`, default 32: map width in pixels.
- `DB_H`, default 32: map height in pixels.
- `DB_C`, default 3: channels per pixel.
- `DIN_W`, default 16: word width.
- `ADDR_WIDTH`, default 12: buffer address width. `DB_W*DB_H*DB_C` must be ≤ 2^`ADDR_WIDTH`; violation is an elaboration error.

Ports:
- `clk` input, 1: single clock. All logic is on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `host_wr_en` input, 1: buffer write strobe.
- `host_wr_addr` input, `ADDR_WIDTH`: buffer write address.
- `host_wr_data` input, `DIN_W`: buffer write data.
- `start` input, 1: one-cycle pulse that begins streaming.
- `busy` output, 1: high from the accepted `start` until the `eop` word is sent.
- `done` output, 1: one-cycle pulse in the cycle after the `eop` word.
- `blob_dout_rdy` input, 1: consumer permission to send.
- `blob_dout_en` output, 1: word valid.
- `blob_dout_eop` output, 1: last word of the map.
- `blob_dout` output, `DIN_W`: word data.

## Operation
- N = `DB_W*DB_H*DB_C`. Words are sent from buffer addresses 0..N-1 in ascending order. The host owns the layout: pixel-major, row-major, with channels innermost.
- States:
  - IDLE → STREAM on `start`.
  - STREAM → DRAIN when the read for address N-1 is issued.
  - DRAIN → IDLE when the `eop` word is emitted.
- IDLE:
  - Host writes are accepted.
  - `busy`=0.
- STREAM:
  - On each edge where `blob_dout_rdy`=1, one RAM read is issued at `rd_addr` and `rd_addr` increments.
  - When `blob_dout_rdy`=0, no read is issued.
- DRAIN: waits until the reads already in flight have emitted.
- `start` while `busy`=1 is ignored.
- `host_wr_en` while `busy`=1 is ignored; the buffer is not modified.
- Simultaneous `start` and `host_wr_en` in IDLE: the write is performed and streaming starts. The word at that address is only guaranteed correct if it is not among the first two reads.
- `blob_dout_eop`=1 exactly on the word read from address N-1. For N=1, `en` and `eop` coincide on the single word.
- `done` pulses once per map. `busy` falls in the same cycle as the `done` pulse.
- `rst` mid-operation:
  - The map is aborted.
  - The next state is IDLE with all counters at 0.
  - Buffer contents are undefined.
  - No `done` or `eop` is produced for the aborted map.

## Timing
- All outputs reset to 0: `busy`, `done`, `blob_dout_en`, `blob_dout_eop`, `blob_dout`.
- Latency:
  - A read issued at edge k produces RAM data after edge k+1.
  - `blob_dout_en` is registered and is high in the cycle following edge k+1.
  - So a word appears 2 cycles after the cycle in which `rdy` was sampled high.
- With `rdy` held high, the first `en` is 3 cycles after the `start` cycle, then N consecutive `en` cycles follow with no gaps.
- After `rdy` falls, at most 2 further words are emitted. The consumer must keep ≥2 words of slack when it deasserts `rdy`.
- `blob_dout` holds its last value when `en`=0. It is not required to be zero.
- `en`, `eop`, `busy` and `done` are glitch-free registered outputs. There is no combinational path from `blob_dout_rdy` to any output.
- Address arithmetic is `ADDR_WIDTH` unsigned. The word counter is `ADDR_WIDTH`+1 bits, so N = 2^`ADDR_WIDTH` is handled without wrap ambiguity.

## Structure
- Shared package `blob_source_pkg` holds:
  - the state enum (IDLE, STREAM, DRAIN);
  - the N and counter-width localparams, computed from `DB_W`, `DB_H`, `DB_C` and `ADDR_WIDTH`.
- Sub-module `blob_source_ram`: simple dual-port RAM, depth 2^`ADDR_WIDTH` by `DIN_W`.
  - Port A is the write port.
  - Port B is a registered read port with 1-cycle latency.
  - It matches the layer row-buffer RAM port naming (`clka`, `wea`, `addra`, `dina`, `clkb`, `addrb`, `doutb`).
- The top level holds the FSM, the read address/count, and a 2-stage valid/eop pipeline aligned to the RAM latency.

## Test plan
- Reset: assert `rst` for 3 cycles → every output is 0. With `start` low, no `en` appears for 20 cycles.
- Full-rate stream: set `DB_W`=2, `DB_H`=2, `DB_C`=2 and preload 0x0001..0x0008. Pulse `start` with `rdy`=1 → `en` is high for 8 consecutive cycles starting 3 cycles after `start`. Data is 0x0001..0x0008. `eop` is asserted only with 0x0008. `done` pulses in the next cycle, when `busy` falls.
- Backpressure: same map, with `rdy` toggling in a 1,1,0,0,0 pattern → data order is preserved with no duplicates or losses. At most 2 `en` occur after each `rdy` fall. Exactly 8 words and 1 `eop` are sent.
- Ignored commands: pulse `start` again mid-stream and write 0xFFFF to address 5 mid-stream → no restart and 0x0006 is still sent. A second `start` after `done` resends 0x0001..0x0008.
- Reset mid-stream: assert `rst` after the 3rd word → outputs are 0 in the next cycle, with no `eop` and no `done`. Reload the buffer and restart → the stream begins at word 0.
- Single word: set `DB_W`=`DB_H`=`DB_C`=1 and preload 0x1234 → one cycle with `en`=`eop`=1 and data 0x1234, followed by a `done` pulse.
